// File: rtl/ltc2308_spi_responder.sv
// LTC2308 serial-port responder: clk-oversampled slave end of the ADC SPI link.
// Captures sample_data on a CONVST rise, holds busy for CONV_CYCLES clocks,
// then serves the sample MSB-first on SDO while collecting the config word on SDI.
module ltc2308_spi_responder #(
    parameter int CONV_CYCLES = 80,
    parameter int DATA_W      = 12,
    parameter int CFG_W       = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              convst,
    input  logic              cs,
    input  logic              sclk,
    input  logic              sdi,
    output logic              sdo,
    output logic              sdo_oe,
    input  logic [DATA_W-1:0] sample_data,
    output logic              busy,
    output logic              conv_done,
    output logic [CFG_W-1:0]  cfg_word,
    output logic              cfg_valid,
    output logic              overrun,
    output logic              frame_abort
);

    localparam int                 BCNT_W    = $clog2(DATA_W + 1);
    localparam logic [BCNT_W-1:0]  FRAME_LEN = BCNT_W'(DATA_W);
    localparam logic [BCNT_W-1:0]  CFG_LEN   = BCNT_W'(CFG_W);
    localparam logic [BCNT_W-1:0]  BCNT_ONE  = BCNT_W'(1);
    localparam logic [15:0]        CONV_LOAD = 16'(CONV_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        READY
    } state_t;

    state_t              state;
    logic [DATA_W-1:0]   data_sr;
    logic [CFG_W-1:0]    cfg_sr;
    logic [15:0]         conv_cnt;
    logic [BCNT_W-1:0]   bit_cnt;

    // p0/p1 form the synchronizer, p2 is the delayed copy used for edge detection
    logic convst_p0, convst_p1, convst_p2;
    logic cs_p0, cs_p1, cs_p2;
    logic sclk_p0, sclk_p1, sclk_p2;
    logic sdi_p0, sdi_p1;

    logic convst_rise;
    logic cs_rise;
    logic sclk_rise;
    logic sclk_fall;
    logic frame_active;
    logic frame_done;

    // Synchronize the asynchronous pins; cs idles high so its chain resets to 1
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            convst_p0 <= 1'b0;
            convst_p1 <= 1'b0;
            convst_p2 <= 1'b0;
            cs_p0     <= 1'b1;
            cs_p1     <= 1'b1;
            cs_p2     <= 1'b1;
            sclk_p0   <= 1'b0;
            sclk_p1   <= 1'b0;
            sclk_p2   <= 1'b0;
            sdi_p0    <= 1'b0;
            sdi_p1    <= 1'b0;
        end else begin
            convst_p0 <= convst;
            convst_p1 <= convst_p0;
            convst_p2 <= convst_p1;
            cs_p0     <= cs;
            cs_p1     <= cs_p0;
            cs_p2     <= cs_p1;
            sclk_p0   <= sclk;
            sclk_p1   <= sclk_p0;
            sclk_p2   <= sclk_p1;
            sdi_p0    <= sdi;
            sdi_p1    <= sdi_p0;
        end
    end

    assign convst_rise  = convst_p1 & ~convst_p2;
    assign cs_rise      = cs_p1 & ~cs_p2;
    assign sclk_rise    = sclk_p1 & ~sclk_p2;
    assign sclk_fall    = ~sclk_p1 & sclk_p2;
    assign frame_active = ~cs_p1;
    // The fall after the last rise closes the frame; it does not shift data
    assign frame_done   = sclk_fall & frame_active & (bit_cnt == FRAME_LEN);

    // Conversion / frame state machine with registered serial and status outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            data_sr     <= '0;
            cfg_sr      <= '0;
            conv_cnt    <= '0;
            bit_cnt     <= '0;
            sdo         <= 1'b0;
            sdo_oe      <= 1'b0;
            busy        <= 1'b0;
            conv_done   <= 1'b0;
            cfg_word    <= '0;
            cfg_valid   <= 1'b0;
            overrun     <= 1'b0;
            frame_abort <= 1'b0;
        end else begin
            conv_done   <= 1'b0;
            cfg_valid   <= 1'b0;
            overrun     <= 1'b0;
            frame_abort <= 1'b0;
            case (state)
                IDLE: begin
                    sdo    <= 1'b0;
                    sdo_oe <= 1'b0;
                    if (convst_rise) begin
                        data_sr  <= sample_data;
                        conv_cnt <= CONV_LOAD;
                        busy     <= 1'b1;
                        state    <= CONVERT;
                    end
                end
                CONVERT: begin
                    // convst and sclk activity are deliberately ignored here
                    sdo    <= 1'b0;
                    sdo_oe <= 1'b0;
                    if (conv_cnt == 16'd0) begin
                        busy      <= 1'b0;
                        conv_done <= 1'b1;
                        bit_cnt   <= '0;
                        cfg_sr    <= '0;
                        sdo       <= data_sr[DATA_W-1];
                        sdo_oe    <= frame_active;
                        state     <= READY;
                    end else begin
                        conv_cnt <= conv_cnt - 16'd1;
                    end
                end
                READY: begin
                    if (frame_done) begin
                        // Completion wins over a coincident convst, which then starts cleanly
                        cfg_word  <= cfg_sr;
                        cfg_valid <= 1'b1;
                        sdo       <= 1'b0;
                        sdo_oe    <= 1'b0;
                        if (convst_rise) begin
                            data_sr  <= sample_data;
                            conv_cnt <= CONV_LOAD;
                            busy     <= 1'b1;
                            state    <= CONVERT;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (convst_rise) begin
                        // Unread sample is discarded in favour of the new one
                        overrun  <= 1'b1;
                        data_sr  <= sample_data;
                        conv_cnt <= CONV_LOAD;
                        busy     <= 1'b1;
                        sdo      <= 1'b0;
                        sdo_oe   <= 1'b0;
                        state    <= CONVERT;
                    end else if (cs_rise && (bit_cnt != '0) && (bit_cnt < FRAME_LEN)) begin
                        frame_abort <= 1'b1;
                        sdo         <= 1'b0;
                        sdo_oe      <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        sdo_oe <= frame_active;
                        sdo    <= data_sr[DATA_W-1];
                        if (sclk_rise && frame_active && (bit_cnt < FRAME_LEN)) begin
                            if (bit_cnt < CFG_LEN) begin
                                cfg_sr <= {cfg_sr[CFG_W-2:0], sdi_p1};
                            end
                            bit_cnt <= bit_cnt + BCNT_ONE;
                        end
                        if (sclk_fall && frame_active && (bit_cnt < FRAME_LEN)) begin
                            data_sr <= {data_sr[DATA_W-2:0], 1'b0};
                            sdo     <= data_sr[DATA_W-2];
                        end
                    end
                end
                default: begin
                    sdo    <= 1'b0;
                    sdo_oe <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ltc2308_spi_responder.sv
// Bench for ltc2308_spi_responder: acts as the SPI initiator and compares the
// serial readback and status pulses against a transaction-level model.
module tb_ltc2308_spi_responder;

    localparam int CONV_CYCLES = 80;
    localparam int DATA_W      = 12;
    localparam int CFG_W       = 6;
    localparam int SCLK_HALF   = 5;

    logic              clk = 1'b0;
    logic              reset;
    logic              convst;
    logic              cs;
    logic              sclk;
    logic              sdi;
    logic              sdo;
    logic              sdo_oe;
    logic [DATA_W-1:0] sample_data;
    logic              busy;
    logic              conv_done;
    logic [CFG_W-1:0]  cfg_word;
    logic              cfg_valid;
    logic              overrun;
    logic              frame_abort;

    int n_checks = 0;
    int n_fail   = 0;

    // model state: last config word from a completed frame
    logic [CFG_W-1:0] exp_cfg = '0;

    // pulse / duration monitor
    int n_done = 0;
    int n_cfgv = 0;
    int n_ovr  = 0;
    int n_abt  = 0;
    int busy_run = 0;
    int last_busy_len = 0;

    ltc2308_spi_responder #(
        .CONV_CYCLES(CONV_CYCLES),
        .DATA_W     (DATA_W),
        .CFG_W      (CFG_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .convst     (convst),
        .cs         (cs),
        .sclk       (sclk),
        .sdi        (sdi),
        .sdo        (sdo),
        .sdo_oe     (sdo_oe),
        .sample_data(sample_data),
        .busy       (busy),
        .conv_done  (conv_done),
        .cfg_word   (cfg_word),
        .cfg_valid  (cfg_valid),
        .overrun    (overrun),
        .frame_abort(frame_abort)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (conv_done)   n_done <= n_done + 1;
        if (cfg_valid)   n_cfgv <= n_cfgv + 1;
        if (overrun)     n_ovr  <= n_ovr + 1;
        if (frame_abort) n_abt  <= n_abt + 1;
        if (busy) begin
            busy_run <= busy_run + 1;
        end else if (busy_run != 0) begin
            last_busy_len <= busy_run;
            busy_run      <= 0;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_convst(input logic [DATA_W-1:0] val);
        sample_data = val;
        convst = 1'b1;
        tick(3);
        convst = 1'b0;
        tick(1);
    endtask

    task automatic wait_done(input string name);
        int base;
        bit seen;
        base = n_done;
        seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (n_done != base) begin
                seen = 1'b1;
                break;
            end
            tick(1);
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: conv_done not seen within 400 clk", name);
        end
        tick(2);
    endtask

    // Initiator side of a frame: cs low, then nclk sclk periods; cs is left low
    task automatic run_frame(input logic [CFG_W-1:0] cfg, input int nclk,
                             output logic [DATA_W-1:0] rx, output bit oe_ok);
        rx = '0;
        oe_ok = 1'b1;
        sdi = cfg[CFG_W-1];
        cs = 1'b0;
        tick(6);
        for (int i = 0; i < nclk; i++) begin
            rx = {rx[DATA_W-2:0], sdo};
            if (sdo_oe !== 1'b1) oe_ok = 1'b0;
            sclk = 1'b1;
            tick(SCLK_HALF);
            sclk = 1'b0;
            if (i < CFG_W - 1) sdi = cfg[CFG_W-2-i];
            else               sdi = 1'($urandom);
            tick(SCLK_HALF);
        end
    endtask

    // Full transaction: convert, read DATA_W bits, close cs; checks data, cfg, pulses
    task automatic full_transaction(input string name, input logic [DATA_W-1:0] val,
                                    input logic [CFG_W-1:0] cfg);
        logic [DATA_W-1:0] rx;
        bit oe_ok;
        int b_cfgv, b_ovr;
        b_cfgv = n_cfgv;
        b_ovr  = n_ovr;
        pulse_convst(val);
        wait_done(name);
        run_frame(cfg, DATA_W, rx, oe_ok);
        tick(4);
        exp_cfg = cfg;
        n_checks++;
        if (rx !== val) begin
            n_fail++;
            $display("FAIL %s_rx: got %03h expected %03h", name, rx, val);
        end
        n_checks++;
        if (cfg_word !== exp_cfg) begin
            n_fail++;
            $display("FAIL %s_cfg: got %02h expected %02h", name, cfg_word, exp_cfg);
        end
        n_checks++;
        if ((n_cfgv - b_cfgv) != 1 || (n_ovr - b_ovr) != 0 || !oe_ok) begin
            n_fail++;
            $display("FAIL %s_flags: cfg_valid pulses %0d overrun pulses %0d oe_ok %0d, expected 1 0 1",
                     name, n_cfgv - b_cfgv, n_ovr - b_ovr, oe_ok);
        end
        cs = 1'b1;
        tick(4);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        convst = 1'b0;
        cs = 1'b1;
        sclk = 1'b0;
        sdi = 1'b0;
        sample_data = '0;
        tick(3);
        n_checks++;
        if ({sdo, sdo_oe, busy, conv_done, cfg_valid, overrun, frame_abort} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %07b expected 0000000",
                     {sdo, sdo_oe, busy, conv_done, cfg_valid, overrun, frame_abort});
        end
        n_checks++;
        if (cfg_word !== '0) begin
            n_fail++;
            $display("FAIL reset_cfg: got %02h expected 00", cfg_word);
        end
        reset = 1'b0;
        tick(3);
    endtask

    task automatic test_basic();
        logic [DATA_W-1:0] rx;
        bit oe_ok;
        int b_done, b_cfgv, b_abt;
        b_done = n_done;
        b_cfgv = n_cfgv;
        b_abt  = n_abt;
        pulse_convst(12'hA5C);
        wait_done("basic");
        n_checks++;
        if (last_busy_len != CONV_CYCLES || (n_done - b_done) != 1) begin
            n_fail++;
            $display("FAIL basic_busy: busy %0d clk, done pulses %0d; expected %0d clk, 1 pulse",
                     last_busy_len, n_done - b_done, CONV_CYCLES);
        end
        // cs toggled without sclk: no abort, data stays available
        cs = 1'b0;
        tick(6);
        cs = 1'b1;
        tick(6);
        n_checks++;
        if ((n_abt - b_abt) != 0) begin
            n_fail++;
            $display("FAIL basic_idle_cs: frame_abort pulses %0d expected 0", n_abt - b_abt);
        end
        run_frame(6'b100010, DATA_W, rx, oe_ok);
        tick(6);
        exp_cfg = 6'b100010;
        n_checks++;
        if (rx !== 12'hA5C) begin
            n_fail++;
            $display("FAIL basic_rx: got %03h expected a5c", rx);
        end
        n_checks++;
        if (!oe_ok) begin
            n_fail++;
            $display("FAIL basic_oe_during: sdo_oe low during frame, expected high");
        end
        n_checks++;
        if (sdo_oe !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_oe_after: got %b expected 0", sdo_oe);
        end
        n_checks++;
        if (cfg_word !== exp_cfg || (n_cfgv - b_cfgv) != 1) begin
            n_fail++;
            $display("FAIL basic_cfg: got %02h with %0d pulses expected %02h with 1",
                     cfg_word, n_cfgv - b_cfgv, exp_cfg);
        end
        cs = 1'b1;
        tick(4);
    endtask

    task automatic test_back_to_back();
        int b_ovr;
        b_ovr = n_ovr;
        full_transaction("b2b_0", 12'h000, 6'h3F);
        full_transaction("b2b_1", 12'hFFF, 6'h15);
        n_checks++;
        if (cfg_word !== 6'h15 || (n_ovr - b_ovr) != 0) begin
            n_fail++;
            $display("FAIL b2b_end: cfg %02h overrun %0d expected 15 and 0", cfg_word, n_ovr - b_ovr);
        end
    endtask

    task automatic do_abort(input string name, input int nclk);
        logic [DATA_W-1:0] val;
        logic [DATA_W-1:0] rx;
        logic [DATA_W-1:0] exp_part;
        bit oe_ok;
        int b_abt, b_cfgv;
        val = DATA_W'($urandom);
        b_abt  = n_abt;
        b_cfgv = n_cfgv;
        pulse_convst(val);
        wait_done(name);
        run_frame(CFG_W'($urandom), nclk, rx, oe_ok);
        cs = 1'b1;
        tick(6);
        exp_part = val >> (DATA_W - nclk);
        n_checks++;
        if ((n_abt - b_abt) != 1 || (n_cfgv - b_cfgv) != 0) begin
            n_fail++;
            $display("FAIL %s_pulse: frame_abort %0d cfg_valid %0d expected 1 and 0",
                     name, n_abt - b_abt, n_cfgv - b_cfgv);
        end
        n_checks++;
        if (cfg_word !== exp_cfg || sdo_oe !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_state: cfg %02h oe %b expected %02h and 0", name, cfg_word, sdo_oe, exp_cfg);
        end
        n_checks++;
        if (rx !== exp_part) begin
            n_fail++;
            $display("FAIL %s_partial: got %03h expected %03h", name, rx, exp_part);
        end
    endtask

    task automatic test_abort();
        do_abort("abort", 5);
        full_transaction("abort_next", DATA_W'($urandom), CFG_W'($urandom));
    endtask

    task automatic test_overrun();
        logic [DATA_W-1:0] rx;
        bit oe_ok;
        int b_ovr;
        b_ovr = n_ovr;
        pulse_convst(DATA_W'($urandom));
        wait_done("ovr_first");
        pulse_convst(12'h123);
        wait_done("ovr_second");
        n_checks++;
        if ((n_ovr - b_ovr) != 1) begin
            n_fail++;
            $display("FAIL ovr_pulse: got %0d pulses expected 1", n_ovr - b_ovr);
        end
        run_frame(6'h2A, DATA_W, rx, oe_ok);
        tick(4);
        exp_cfg = 6'h2A;
        n_checks++;
        if (rx !== 12'h123 || cfg_word !== exp_cfg) begin
            n_fail++;
            $display("FAIL ovr_rx: got %03h/%02h expected 123/%02h", rx, cfg_word, exp_cfg);
        end
        cs = 1'b1;
        tick(4);
    endtask

    task automatic test_convst_during_conversion();
        logic [DATA_W-1:0] first_val;
        logic [DATA_W-1:0] rx;
        bit oe_ok;
        int b_done, b_ovr;
        first_val = DATA_W'($urandom);
        b_done = n_done;
        b_ovr  = n_ovr;
        pulse_convst(first_val);
        tick(16);
        pulse_convst(~first_val);
        wait_done("conv_ign");
        tick(4);
        n_checks++;
        if (last_busy_len != CONV_CYCLES || (n_done - b_done) != 1 || (n_ovr - b_ovr) != 0) begin
            n_fail++;
            $display("FAIL conv_ign_busy: busy %0d done %0d overrun %0d expected %0d 1 0",
                     last_busy_len, n_done - b_done, n_ovr - b_ovr, CONV_CYCLES);
        end
        run_frame(6'h0C, DATA_W, rx, oe_ok);
        tick(4);
        exp_cfg = 6'h0C;
        n_checks++;
        if (rx !== first_val) begin
            n_fail++;
            $display("FAIL conv_ign_rx: got %03h expected %03h", rx, first_val);
        end
        cs = 1'b1;
        tick(4);
    endtask

    task automatic test_reset_mid_frame();
        logic [DATA_W-1:0] rx;
        bit oe_ok;
        pulse_convst(DATA_W'($urandom));
        wait_done("rst_mid");
        run_frame(6'h33, 7, rx, oe_ok);
        reset = 1'b1;
        #1;
        n_checks++;
        if ({sdo, sdo_oe, busy} !== 3'b000 || cfg_word !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_outputs: sdo/oe/busy %03b cfg %02h expected 000 and 00",
                     {sdo, sdo_oe, busy}, cfg_word);
        end
        cs = 1'b1;
        sclk = 1'b0;
        tick(3);
        reset = 1'b0;
        exp_cfg = '0;
        tick(3);
        full_transaction("rst_after", DATA_W'($urandom), CFG_W'($urandom));
    endtask

    task automatic test_random();
        logic [DATA_W-1:0] rx;
        logic [DATA_W-1:0] v2;
        bit oe_ok;
        int mode, b_ovr;
        for (int k = 0; k < 10; k++) begin
            mode = int'($urandom_range(0, 2));
            if (mode == 0) begin
                full_transaction("rand_full", DATA_W'($urandom), CFG_W'($urandom));
            end else if (mode == 1) begin
                do_abort("rand_abort", int'($urandom_range(1, DATA_W - 1)));
            end else begin
                b_ovr = n_ovr;
                v2 = DATA_W'($urandom);
                pulse_convst(DATA_W'($urandom));
                wait_done("rand_ovr1");
                pulse_convst(v2);
                wait_done("rand_ovr2");
                run_frame(~exp_cfg, DATA_W, rx, oe_ok);
                tick(4);
                exp_cfg = ~exp_cfg;
                n_checks++;
                if (rx !== v2 || cfg_word !== exp_cfg || (n_ovr - b_ovr) != 1) begin
                    n_fail++;
                    $display("FAIL rand_ovr: rx %03h cfg %02h ovr %0d expected %03h %02h 1",
                             rx, cfg_word, n_ovr - b_ovr, v2, exp_cfg);
                end
                cs = 1'b1;
                tick(4);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_abort();
        test_overrun();
        test_convst_during_conversion();
        test_reset_mid_frame();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ltc2308_spi_responder.md
Name: ltc2308_spi_responder

Overview:
- Synthesizable, clk-oversampled model of the LTC2308 ADC serial port: the slave/responder end of the LTC2308 SPI link.
- Accepts CONVST and runs a fixed-length conversion. During the 12-clock frame it shifts the captured 12-bit sample out on SDO and shifts the 6-bit configuration word in from SDI.
- Stands in for the physical ADC in loopback tests of the SPI initiator. It also feeds FPGA-side stimulus (sample_data) into the serial link.

Parameters:
- CONV_CYCLES, 80, conversion time in clk cycles (1.6 us at 50 MHz); legal range 2 to 65535.
- DATA_W, 12, sample/frame length in bits.
- CFG_W, 6, config word bits captured at frame start (S/D, O/S, S1, S0, UNI, SLP); must satisfy CFG_W ≤ DATA_W.

Ports:
- clk  in  1  system clock; must be ≥ 8x the sclk frequency.
- reset  in  1  asynchronous, active-high.
- convst  in  1  conversion start from initiator; rising edge starts a conversion.
- cs  in  1  frame enable, active-low.
- sclk  in  1  serial clock from initiator.
- sdi  in  1  serial config data from initiator.
- sdo  out  1  serial sample data to initiator.
- sdo_oe  out  1  SDO drive enable (top level tri-states when 0).
- sample_data  in  DATA_W  value to be "converted"; captured at the convst edge.
- busy  out  1  high during conversion.
- conv_done  out  1  one-clk pulse at end of conversion.
- cfg_word  out  CFG_W  last complete config word received.
- cfg_valid  out  1  one-clk pulse when cfg_word updates.
- overrun  out  1  one-clk pulse when unread data is discarded.
- frame_abort  out  1  one-clk pulse when cs deasserts mid-frame.

Behaviour:
- Reset values: sdo=0, sdo_oe=0, busy=0, conv_done=0, cfg_word=0, cfg_valid=0, overrun=0, frame_abort=0, state=IDLE, counters=0.
- Input sampling:
  - convst, cs, sclk and sdi each pass through a 2-flop synchronizer.
  - Edges are detected by comparing the synchronized value with a third delayed flop.
  - All actions occur on the clk after edge detection, i.e. 3 clk after the pin changes.
  - sdi is sampled from its synchronized value in the same cycle the sclk rising edge is detected.
- State IDLE:
  - On a convst rise: load data_sr <= sample_data, load conv_cnt <= CONV_CYCLES-1, set busy=1, go to CONVERT.
- State CONVERT:
  - conv_cnt decrements each clk.
  - When conv_cnt==0: busy<=0, conv_done pulses, bit_cnt<=0, go to READY.
  - A convst rise in CONVERT is ignored: no restart, no flag.
  - sclk activity in CONVERT is ignored.
- State READY (frame):
  - sdo_oe = ~cs_sync. sdo = data_sr[DATA_W-1] (MSB first). The MSB is valid before the first sclk edge.
  - On an sclk rise while cs_sync==0:
    - If bit_cnt < CFG_W, shift sdi into cfg_sr (first bit lands as MSB).
    - bit_cnt increments.
  - On an sclk fall while cs_sync==0 and bit_cnt < DATA_W: data_sr <= data_sr << 1, zero-filled.
  - Frame completes on the sclk fall following the DATA_W-th rise:
    - cfg_word <= cfg_sr, cfg_valid pulses, sdo_oe<=0, sdo<=0, go to IDLE.
  - A cs rise with 0 < bit_cnt < DATA_W: frame_abort pulses, cfg_word is unchanged, sdo_oe<=0, go to IDLE.
  - A cs rise with bit_cnt==0: stay in READY; data is still available.
  - A convst rise in READY before frame completion: overrun pulses, the new sample is captured, go to CONVERT (old data lost).
  - If a convst rise and a frame-completing sclk fall are detected in the same clk: the frame completes first (cfg_valid pulses), then the conversion starts. The block goes to CONVERT and overrun stays 0.
- Outside READY: sdo=0, sdo_oe=0.
- Reset mid-operation: all state and outputs return to reset values immediately. A partially received config word is discarded.

Test Plan:
- Basic conversion: sample_data=12'hA5C, convst pulse → busy high for exactly 80 clk, then conv_done pulses. Then cs low plus 12 sclk with sdi pattern 6'b100010 → initiator receives 12'hA5C MSB first; cfg_word=6'b100010 with one cfg_valid pulse; sdo_oe drops after the 12th fall.
- Back-to-back frames: two conversions with 12'h000 then 12'hFFF, config words 6'h3F then 6'h15 → both samples read correctly; cfg_word ends at 6'h15; overrun never asserts.
- Abort: cs rises after 5 sclk → frame_abort pulses once; cfg_word keeps its previous value; state returns to IDLE; the next convst/frame works normally.
- Overrun: convst, wait conv_done, then convst again without a frame, sample_data=12'h123 → overrun pulses once; the following frame returns 12'h123.
- Convst during conversion: second convst 20 clk after the first → ignored; busy still lasts 80 clk total; the first sample is read out.
- Reset: assert reset in the middle of a frame (bit 7) → sdo=0, sdo_oe=0, busy=0, cfg_word=0 within the same clk. A subsequent full transaction is correct.
